// File: rtl/l2_block_transfer_sequencer_if.sv
// Memory operation type and the L2/memory-side bundle of the block transfer sequencer.
// The sequencer uses the master view; the L2 controller and memory model use the slave view.
package l2_block_transfer_sequencer_pkg;
    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;
endpackage

interface l2_block_transfer_sequencer_if
    import l2_block_transfer_sequencer_pkg::*;
#(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned WORDS_PER_BLOCK = 4
);
    localparam int unsigned BLK_W = WORDS_PER_BLOCK * XLEN;

    logic                 blk_req_valid;
    logic                 blk_req_writeback;
    logic [XLEN-1:0]      blk_fill_address;
    logic [XLEN-1:0]      blk_victim_address;
    logic [BLK_W-1:0]     blk_wb_data;
    logic                 blk_ready;
    logic [BLK_W-1:0]     blk_fill_data;
    logic                 blk_done;

    logic [XLEN-1:0]      mem_req_address;
    memory_operation_e    mem_req_type;
    logic                 mem_req_valid;
    logic [XLEN-1:0]      mem_word_to_store;
    logic [XLEN-1:0]      mem_fetched_word;
    logic                 mem_req_fulfilled;

    modport master (
        input  blk_req_valid, blk_req_writeback, blk_fill_address, blk_victim_address,
               blk_wb_data, mem_fetched_word, mem_req_fulfilled,
        output blk_ready, blk_fill_data, blk_done,
               mem_req_address, mem_req_type, mem_req_valid, mem_word_to_store
    );

    modport slave (
        output blk_req_valid, blk_req_writeback, blk_fill_address, blk_victim_address,
               blk_wb_data, mem_fetched_word, mem_req_fulfilled,
        input  blk_ready, blk_fill_data, blk_done,
               mem_req_address, mem_req_type, mem_req_valid, mem_word_to_store
    );
endinterface

// File: rtl/l2_block_transfer_sequencer.sv
// Breaks an L2 block request (optional victim writeback, then fill) into ascending
// per-word memory beats and assembles the fetched words into a block buffer.
module l2_block_transfer_sequencer
    import l2_block_transfer_sequencer_pkg::*;
#(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned WORDS_PER_BLOCK = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    l2_block_transfer_sequencer_if.master bus
);
    localparam int unsigned BLOCK_BYTES = WORDS_PER_BLOCK * XLEN / 8;
    localparam int unsigned OFS         = $clog2(BLOCK_BYTES);
    localparam int unsigned BEAT_W      = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned WORD_SH     = $clog2(XLEN / 8);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [XLEN-1:0]   BASE_MASK = ~((XLEN'(1) << OFS) - XLEN'(1));

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_FILL      = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    typedef logic [WORDS_PER_BLOCK-1:0][XLEN-1:0] block_t;

    logic [1:0]        state_q,       state_d;
    logic [BEAT_W-1:0] beat_q,        beat_d;
    logic [XLEN-1:0]   fill_base_q,   fill_base_d;
    logic [XLEN-1:0]   victim_base_q, victim_base_d;
    block_t            wb_words_q,    wb_words_d;
    block_t            fill_words_q,  fill_words_d;

    logic              blk_ready_q,   blk_ready_d;
    logic              blk_done_q,    blk_done_d;
    logic              mem_valid_q,   mem_valid_d;
    logic [XLEN-1:0]   mem_addr_q,    mem_addr_d;
    memory_operation_e mem_type_q,    mem_type_d;
    logic [XLEN-1:0]   mem_store_q,   mem_store_d;

    // State, captured request and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            beat_q        <= '0;
            fill_base_q   <= '0;
            victim_base_q <= '0;
            wb_words_q    <= '0;
            fill_words_q  <= '0;
            blk_ready_q   <= 1'b1;
            blk_done_q    <= 1'b0;
            mem_valid_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_type_q    <= LOAD;
            mem_store_q   <= '0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            fill_base_q   <= fill_base_d;
            victim_base_q <= victim_base_d;
            wb_words_q    <= wb_words_d;
            fill_words_q  <= fill_words_d;
            blk_ready_q   <= blk_ready_d;
            blk_done_q    <= blk_done_d;
            mem_valid_q   <= mem_valid_d;
            mem_addr_q    <= mem_addr_d;
            mem_type_q    <= mem_type_d;
            mem_store_q   <= mem_store_d;
        end
    end

    // Next state, beat sequencing, and output decode from the next-state values so the
    // registered outputs show the beat of the cycle they appear in.
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        fill_base_d   = fill_base_q;
        victim_base_d = victim_base_q;
        wb_words_d    = wb_words_q;
        fill_words_d  = fill_words_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.blk_req_valid) begin
                    fill_base_d   = bus.blk_fill_address & BASE_MASK;
                    victim_base_d = bus.blk_victim_address & BASE_MASK;
                    wb_words_d    = bus.blk_wb_data;
                    beat_d        = '0;
                    state_d       = bus.blk_req_writeback ? ST_WRITEBACK : ST_FILL;
                end
            end
            ST_WRITEBACK: begin
                if (bus.mem_req_fulfilled) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = ST_FILL;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            ST_FILL: begin
                if (bus.mem_req_fulfilled) begin
                    fill_words_d[beat_q] = bus.mem_fetched_word;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        blk_ready_d = (state_d == ST_IDLE);
        blk_done_d  = (state_d == ST_DONE);
        mem_valid_d = 1'b0;
        mem_addr_d  = '0;
        mem_type_d  = LOAD;
        mem_store_d = '0;

        if (state_d == ST_WRITEBACK) begin
            mem_valid_d = 1'b1;
            mem_type_d  = STORE;
            mem_addr_d  = victim_base_d + (XLEN'(beat_d) << WORD_SH);
            mem_store_d = wb_words_d[beat_d];
        end else if (state_d == ST_FILL) begin
            mem_valid_d = 1'b1;
            mem_type_d  = LOAD;
            mem_addr_d  = fill_base_d + (XLEN'(beat_d) << WORD_SH);
        end
    end

    assign bus.blk_ready         = blk_ready_q;
    assign bus.blk_done          = blk_done_q;
    assign bus.blk_fill_data     = fill_words_q;
    assign bus.mem_req_valid     = mem_valid_q;
    assign bus.mem_req_address   = mem_addr_q;
    assign bus.mem_req_type      = mem_type_q;
    assign bus.mem_word_to_store = mem_store_q;

endmodule

// File: tb/tb_l2_block_transfer_sequencer.sv
// Directed, table-driven bench for l2_block_transfer_sequencer plus hand-written
// reset-mid-writeback sequence.
module tb_l2_block_transfer_sequencer;
    import l2_block_transfer_sequencer_pkg::*;

    localparam int K_IDLE  = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_DONE  = 3;

    localparam logic [127:0] WB_DATA = 128'h00000044_00000033_00000022_00000011;
    localparam logic [127:0] FILL_A  = 128'h000000A3_000000A2_000000A1_000000A0;
    localparam logic [127:0] FILL_B  = 128'h000000B3_000000B2_000000B1_000000B0;
    localparam logic [127:0] FILL_C  = 128'h000000C3_000000C2_000000C1_000000C0;
    localparam logic [127:0] FILL_D  = 128'h000000D3_000000D2_000000D1_000000D0;
    localparam logic [127:0] FILL_E  = 128'h000000E3_000000E2_000000E1_000000E0;

    typedef struct {
        logic         rv;
        logic         wb;
        logic [31:0]  fa;
        logic [31:0]  va;
        logic         ful;
        logic [31:0]  fw;
        int           kind;
        logic [31:0]  e_addr;
        logic [31:0]  e_data;
        logic         chk_fill;
        logic [127:0] e_fill;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    l2_block_transfer_sequencer_if #(.XLEN(32), .WORDS_PER_BLOCK(4)) bus ();

    l2_block_transfer_sequencer #(.XLEN(32), .WORDS_PER_BLOCK(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic void add(input logic rv, input logic wb, input logic [31:0] fa,
                                input logic [31:0] va, input logic ful, input logic [31:0] fw,
                                input int kind, input logic [31:0] ea, input logic [31:0] ed,
                                input logic cf, input logic [127:0] ef);
        vec_t v;
        v.rv = rv; v.wb = wb; v.fa = fa; v.va = va; v.ful = ful; v.fw = fw;
        v.kind = kind; v.e_addr = ea; v.e_data = ed; v.chk_fill = cf; v.e_fill = ef;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " ready"}, 128'(bus.blk_ready), 128'(1'b1));
        check({tag, " done"},  128'(bus.blk_done), 128'(1'b0));
        check({tag, " valid"}, 128'(bus.mem_req_valid), 128'(1'b0));
        check({tag, " addr"},  128'(bus.mem_req_address), 128'(0));
        check({tag, " type"},  128'(bus.mem_req_type), 128'(LOAD));
        check({tag, " store"}, 128'(bus.mem_word_to_store), 128'(0));
    endtask

    initial begin
        int beats;
        bit done_seen;
        reset = 1'b1;
        bus.blk_req_valid      = 1'b0;
        bus.blk_req_writeback  = 1'b0;
        bus.blk_fill_address   = '0;
        bus.blk_victim_address = '0;
        bus.blk_wb_data        = WB_DATA;
        bus.mem_req_fulfilled  = 1'b0;
        bus.mem_fetched_word   = '0;

        // Fill only, zero wait.
        add(1, 0, 32'h1234, 0, 0, 0,     K_IDLE, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'hA0,       K_LOAD, 32'h1230, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'hA1,       K_LOAD, 32'h1234, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'hA2,       K_LOAD, 32'h1238, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'hA3,       K_LOAD, 32'h123C, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,            K_DONE, 0, 0, 1, FILL_A);
        add(0, 0, 0, 0, 0, 0,            K_IDLE, 0, 0, 1, FILL_A);
        // Writeback then fill; old fill data held during writeback.
        add(1, 1, 32'h3000, 32'h2008, 0, 0, K_IDLE, 0, 0, 1, FILL_A);
        add(0, 0, 0, 0, 1, 32'hDEAD,     K_STORE, 32'h2000, 32'h11, 1, FILL_A);
        add(0, 0, 0, 0, 1, 32'hDEAD,     K_STORE, 32'h2004, 32'h22, 1, FILL_A);
        add(0, 0, 0, 0, 1, 32'hDEAD,     K_STORE, 32'h2008, 32'h33, 1, FILL_A);
        add(0, 0, 0, 0, 1, 32'hDEAD,     K_STORE, 32'h200C, 32'h44, 1, FILL_A);
        add(0, 0, 0, 0, 1, 32'hB0,       K_LOAD, 32'h3000, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'hB1,       K_LOAD, 32'h3004, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'hB2,       K_LOAD, 32'h3008, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'hB3,       K_LOAD, 32'h300C, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,            K_DONE, 0, 0, 1, FILL_B);
        add(0, 0, 0, 0, 0, 0,            K_IDLE, 0, 0, 1, FILL_B);
        // Stall of 3 cycles on beat 2, spurious request while busy.
        add(1, 0, 32'h1234, 0, 0, 0,     K_IDLE, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'hC0,       K_LOAD, 32'h1230, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'hC1,       K_LOAD, 32'h1234, 0, 0, 0);
        add(1, 0, 32'h5000, 0, 0, 0,     K_LOAD, 32'h1238, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,            K_LOAD, 32'h1238, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,            K_LOAD, 32'h1238, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'hC2,       K_LOAD, 32'h1238, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'hC3,       K_LOAD, 32'h123C, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,            K_DONE, 0, 0, 1, FILL_C);
        // Spurious fulfilled in idle changes nothing.
        add(0, 0, 0, 0, 1, 32'hEE,       K_IDLE, 0, 0, 1, FILL_C);
        add(0, 0, 0, 0, 0, 0,            K_IDLE, 0, 0, 1, FILL_C);
        add(0, 0, 0, 0, 0, 0,            K_IDLE, 0, 0, 1, FILL_C);
        // Address wrap at top of address space.
        add(1, 0, 32'hFFFF_FFF4, 0, 0, 0, K_IDLE, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'hD0,       K_LOAD, 32'hFFFF_FFF0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'hD1,       K_LOAD, 32'hFFFF_FFF4, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'hD2,       K_LOAD, 32'hFFFF_FFF8, 0, 0, 0);
        add(0, 0, 0, 0, 1, 32'hD3,       K_LOAD, 32'hFFFF_FFFC, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,            K_DONE, 0, 0, 1, FILL_D);
        add(0, 0, 0, 0, 0, 0,            K_IDLE, 0, 0, 1, FILL_D);

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        check("reset fill_data", bus.blk_fill_data, 128'(0));
        reset = 1'b0;

        foreach (vecs[i]) begin
            vec_t v;
            string tag;
            memory_operation_e et;
            v   = vecs[i];
            tag = $sformatf("row%0d", i);
            et  = (v.kind == K_STORE) ? STORE : LOAD;
            @(negedge clk);
            check({tag, " ready"}, 128'(bus.blk_ready), 128'(v.kind == K_IDLE));
            check({tag, " done"},  128'(bus.blk_done), 128'(v.kind == K_DONE));
            check({tag, " valid"}, 128'(bus.mem_req_valid),
                  128'(v.kind == K_LOAD || v.kind == K_STORE));
            check({tag, " type"},  128'(bus.mem_req_type), 128'(et));
            check({tag, " addr"},  128'(bus.mem_req_address), 128'(v.e_addr));
            check({tag, " store"}, 128'(bus.mem_word_to_store), 128'(v.e_data));
            if (v.chk_fill) check({tag, " fill_data"}, bus.blk_fill_data, v.e_fill);
            bus.blk_req_valid      = v.rv;
            bus.blk_req_writeback  = v.wb;
            bus.blk_fill_address   = v.fa;
            bus.blk_victim_address = v.va;
            bus.mem_req_fulfilled  = v.ful;
            bus.mem_fetched_word   = v.fw;
        end

        // Reset during writeback beat 1.
        @(negedge clk);
        bus.blk_req_valid      = 1'b1;
        bus.blk_req_writeback  = 1'b1;
        bus.blk_victim_address = 32'h4000;
        bus.blk_fill_address   = 32'h0080;
        bus.mem_req_fulfilled  = 1'b0;
        @(negedge clk);
        bus.blk_req_valid = 1'b0;
        check("rstwb beat0 addr", 128'(bus.mem_req_address), 128'(32'h4000));
        bus.mem_req_fulfilled = 1'b1;
        @(negedge clk);
        check("rstwb beat1 addr", 128'(bus.mem_req_address), 128'(32'h4004));
        check("rstwb beat1 valid", 128'(bus.mem_req_valid), 128'(1'b1));
        bus.mem_req_fulfilled = 1'b0;
        reset = 1'b1;
        #1;
        check_idle_outputs("rstwb async");
        check("rstwb fill_data", bus.blk_fill_data, 128'(0));
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("rstwb quiet%0d done", k), 128'(bus.blk_done), 128'(1'b0));
            check($sformatf("rstwb quiet%0d valid", k), 128'(bus.mem_req_valid), 128'(1'b0));
        end

        // Fill after reset, served by a small memory responder.
        bus.blk_req_valid     = 1'b1;
        bus.blk_req_writeback = 1'b0;
        bus.blk_fill_address  = 32'h0044;
        beats     = 0;
        done_seen = 1'b0;
        for (int k = 0; k < 20 && !done_seen; k++) begin
            @(negedge clk);
            bus.blk_req_valid = 1'b0;
            if (bus.blk_done) begin
                done_seen = 1'b1;
                bus.mem_req_fulfilled = 1'b0;
            end else if (bus.mem_req_valid) begin
                check($sformatf("post beat%0d addr", beats), 128'(bus.mem_req_address),
                      128'(32'h40 + 32'(beats) * 4));
                bus.mem_req_fulfilled = 1'b1;
                bus.mem_fetched_word  = 32'hE0 + ((bus.mem_req_address & 32'hC) >> 2);
                beats++;
            end else begin
                bus.mem_req_fulfilled = 1'b0;
            end
        end
        check("post done seen", 128'(done_seen), 128'(1'b1));
        check("post beat count", 128'(beats), 128'(4));
        check("post fill_data", bus.blk_fill_data, FILL_E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
